// File: rtl/ram_bus_responder.sv
// Data-RAM port responder: bridges core MEM-stage accesses onto a level-held req/ack memory bus.
// Latency: request seen in cycle N, earliest ack in N+1, read data presented in DONE at N+2.
// Backpressure: stall holds the core while a request is in flight; timeout aborts with a bus_error pulse.
//
// Ports:
//   clk, rst                        - clock (rising edge), asynchronous active-high reset
//   ram_en/ram_write_en/ram_addr/   - core access (all-zero write enables = read)
//   ram_write_data
//   ram_read_data                   - registered read data back to the core
//   stall                           - combinational pipeline freeze
//   mem_req/we/sel/addr/wdata       - registered external bus request, word-aligned address
//   mem_ack/mem_rdata               - external completion and read data
//   bus_error                       - one-cycle pulse (DONE cycle) after a timeout abort
//   wait_cycles                     - saturating count of stalled cycles since reset
module ram_bus_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4,
    parameter int TIMEOUT    = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ram_en,
    input  logic [SEL_WIDTH-1:0]  ram_write_en,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_write_data,
    output logic [DATA_WIDTH-1:0] ram_read_data,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [SEL_WIDTH-1:0]  mem_sel,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  bus_error,
    output logic [CNT_WIDTH-1:0]  wait_cycles
);

    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    // Word-align mask: clears the two byte-offset bits of the core address.
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [SEL_WIDTH-1:0]    mem_sel_q, mem_sel_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    bus_error_q, bus_error_d;
    logic [CNT_WIDTH-1:0]    wait_cycles_q, wait_cycles_d;

    // Stall is combinational so the core freezes in the same cycle ram_en appears.
    // It is gated by rst so the core is released the instant reset asserts.
    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE:     stall = ram_en;
                WAIT_ACK: stall = 1'b1;
                default:  stall = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_sel_d   = mem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        bus_error_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ram_en) begin
                    mem_we_d    = |ram_write_en;
                    mem_sel_d   = (|ram_write_en) ? ram_write_en : {SEL_WIDTH{1'b1}};
                    mem_addr_d  = ram_addr & WORD_MASK;
                    mem_wdata_d = ram_write_data;
                    mem_req_d   = 1'b1;
                    tmo_d       = '0;
                    state_d     = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (mem_ack) begin
                    // Writes leave the core-facing read data untouched.
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                end else if (tmo_q == TMO_LAST) begin
                    mem_req_d   = 1'b0;
                    rdata_d     = '0;
                    bus_error_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            DONE: begin
                // ram_en here is the access just served; never re-issue it.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wait_cycles_d = wait_cycles_q;
        if (stall && (wait_cycles_q != {CNT_WIDTH{1'b1}})) begin
            wait_cycles_d = wait_cycles_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            tmo_q         <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_sel_q     <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rdata_q       <= '0;
            bus_error_q   <= 1'b0;
            wait_cycles_q <= '0;
        end else begin
            state_q       <= state_d;
            tmo_q         <= tmo_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_sel_q     <= mem_sel_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rdata_q       <= rdata_d;
            bus_error_q   <= bus_error_d;
            wait_cycles_q <= wait_cycles_d;
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_sel       = mem_sel_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign ram_read_data = rdata_q;
    assign bus_error     = bus_error_q;
    assign wait_cycles   = wait_cycles_q;

endmodule

// File: doc/ram_bus_responder.md
Name: ram_bus_responder

Overview:
- Sits at the other end of the core's data-RAM port: accepts the core's MEM-stage access (ram_en, byte write enables, address, write data) and returns read data.
- Translates each access into a level-held req/ack transaction on a slower external memory bus.
- Drives the core's global `stall` input while a transaction is outstanding, so the pipeline freezes until data is ready.
- Adds a bus timeout with an error pulse and a saturating wait-cycle counter for debug.

Parameters:
- ADDR_WIDTH, 32, width of ram_addr / mem_addr
- DATA_WIDTH, 32, width of data buses
- SEL_WIDTH, 4, byte-enable width (DATA_WIDTH/8)
- TIMEOUT, 64, max cycles in WAIT_ACK before abort (>=2)
- CNT_WIDTH, 32, width of wait_cycles counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ram_en  in  1  core access request (combinational from MEM stage)
- ram_write_en  in  SEL_WIDTH  byte write enables; all-zero = read
- ram_addr  in  ADDR_WIDTH  byte address from core
- ram_write_data  in  DATA_WIDTH  store data from core
- ram_read_data  out  DATA_WIDTH  registered read data to core
- stall  out  1  pipeline stall to core (combinational)
- mem_req  out  1  external request, registered, held until ack or timeout
- mem_we  out  1  external write strobe, registered
- mem_sel  out  SEL_WIDTH  external byte enables, registered
- mem_addr  out  ADDR_WIDTH  external word address, low 2 bits forced 0
- mem_wdata  out  DATA_WIDTH  external write data, registered
- mem_ack  in  1  external completion, one cycle per transaction
- mem_rdata  in  DATA_WIDTH  external read data, valid when mem_ack=1
- bus_error  out  1  one-cycle pulse on timeout abort
- wait_cycles  out  CNT_WIDTH  saturating count of cycles stall=1

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - mem_req, mem_we, mem_sel, mem_addr, mem_wdata, ram_read_data, bus_error, wait_cycles all 0.
  - stall forced 0 while rst=1.
- States: IDLE, WAIT_ACK, DONE.
- IDLE:
  - If ram_en=1: stall=1 combinationally in the same cycle.
  - Latch the request: mem_we = |ram_write_en; mem_sel = ram_write_en if write, else all-ones; mem_addr = {ram_addr[ADDR_WIDTH-1:2], 2'b00}; mem_wdata = ram_write_data.
  - Set mem_req=1 and go to WAIT_ACK; the wait counter is cleared.
  - If ram_en=0: stall=0, no action.
- WAIT_ACK:
  - stall=1; mem_req=1; outputs to the external bus are stable.
  - On mem_ack=1 with a read: ram_read_data <= mem_rdata. Clear mem_req and go to DONE.
  - On mem_ack=1 with a write: ram_read_data unchanged. Clear mem_req and go to DONE.
  - If no ack and the wait counter == TIMEOUT-1: clear mem_req, ram_read_data <= 0, bus_error <= 1 (for the DONE cycle only), go to DONE.
  - Otherwise increment the wait counter.
- DONE:
  - stall=0 so the core's MEM/WB register captures ram_read_data at this edge.
  - Next state is always IDLE.
  - ram_en in DONE is the same, already-served access and is ignored.
  - bus_error clears on exit.
- Latency: request seen in cycle N; earliest ack in N+1; DONE in N+2. Minimum stall is 2 cycles (N and N+1); a stall cycle is added for each cycle of ack delay.
- Back-to-back accesses: a new ram_en in the cycle after DONE (IDLE) starts a new transaction. There is no idle bubble beyond DONE.
- The core holds ram_* stable while stall=1. The block relies only on the values latched in IDLE.
- mem_ack outside WAIT_ACK is ignored, e.g. a late ack after a timeout. It has no effect on state or data.
- wait_cycles increments each cycle stall=1 and saturates at all-ones.
- Reset mid-transaction returns immediately to IDLE with mem_req=0. The external side must tolerate an abandoned request.

Test Plan:
- Read, ack one cycle after request: ram_en=1, ram_write_en=0, ram_addr=0x1006, mem_rdata=0xCAFEF00D.
  - Required: mem_addr=0x1004, mem_sel=4'hF, mem_we=0.
  - Required: stall high for exactly 2 cycles; ram_read_data=0xCAFEF00D in DONE; wait_cycles=2.
- Byte write, ack delayed 5 cycles: ram_write_en=4'b0100, ram_write_data=0x00AB0000.
  - Required: mem_we=1, mem_sel=4'b0100, mem_req held 6 cycles.
  - Required: stall high 7 cycles; ram_read_data unchanged.
- Timeout: TIMEOUT=8, mem_ack never asserted.
  - Required: mem_req drops after 8 cycles in WAIT_ACK; bus_error pulses 1 cycle; ram_read_data=0.
  - Required: a later spurious mem_ack is ignored (state stays IDLE).
- Back-to-back: read then write in consecutive instructions.
  - Required: the second transaction enters WAIT_ACK the cycle after the first's IDLE re-entry.
  - Required: the two are latched separately, with no duplicate external request.
- Async reset: assert rst mid-WAIT_ACK between clock edges.
  - Required: mem_req=0 and stall=0 immediately.
  - Required: after release, the next ram_en starts a clean transaction and wait_cycles restarts from 0.
